// File: rtl/valid_ready_accum_n.sv
// Valid/ready group accumulator with runtime group length,
// early-terminate sideband and a decoupled result register.
module valid_ready_accum_n #(
  parameter int DW     = 8,
  parameter int MAX_N  = 16,
  parameter int NW     = $clog2(MAX_N+1),
  parameter int OW     = DW + $clog2(MAX_N),
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NW-1:0] cfg_n,
  input  logic [DW-1:0] data_in,
  input  logic          valid_a,
  input  logic          last_a,
  output logic          ready_a,
  output logic          valid_b,
  input  logic          ready_b,
  output logic [OW-1:0] data_out,
  output logic [NW-1:0] cnt_out
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [NW-1:0] LP_MAX = NW'(MAX_N);
  localparam logic [NW-1:0] LP_ONE = NW'(1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [OW-1:0] r_acc;
  logic [NW-1:0] r_cnt;
  logic [NW-1:0] r_nlat;
  logic          r_vb;
  logic [OW-1:0] r_dout;
  logic [NW-1:0] r_cout;

  logic          w_first;
  logic          w_sbit;
  logic [OW-1:0] w_ext;
  logic [OW-1:0] w_sum;
  logic [NW-1:0] w_eff;
  logic [NW-1:0] w_len;
  logic [NW-1:0] w_cnt1;
  logic          w_closing;
  logic          w_fire;
  logic          w_ofire;

  assign w_first = (r_state == IDLE);
  assign w_sbit  = (SIGNED != 0) && data_in[DW-1];
  assign w_ext   = {{(OW-DW){w_sbit}}, data_in};
  assign w_sum   = w_first ? w_ext : r_acc + w_ext;
  assign w_cnt1  = r_cnt + LP_ONE;

  // Clamp the requested group length into 1..MAX_N
  always_comb begin
    w_eff = cfg_n;
    if (cfg_n == '0)
      w_eff = LP_ONE;
    else if (cfg_n > LP_MAX)
      w_eff = LP_MAX;
  end

  assign w_len     = w_first ? w_eff : r_nlat;
  assign w_closing = last_a || (w_cnt1 == w_len);
  // Only a closing beat needs room in the result register
  assign ready_a   = !r_vb || ready_b || !w_closing;
  assign w_fire    = valid_a && ready_a;
  assign w_ofire   = r_vb && ready_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state: open a group on a non-closing first beat,
  // close it on the closing beat
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:  if (w_fire && !w_closing) w_state_nx = ACCUM;
      ACCUM: if (w_fire && w_closing)  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Partial sum, beat counter and latched group length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_nlat <= '0;
    end else if (w_fire) begin
      r_acc <= w_closing ? '0 : w_sum;
      r_cnt <= w_closing ? '0 : w_cnt1;
      if (w_first) r_nlat <= w_eff;
    end
  end

  // Result register: a new load wins over the handshake clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb   <= 1'b0;
      r_dout <= '0;
      r_cout <= '0;
    end else if (w_fire && w_closing) begin
      r_vb   <= 1'b1;
      r_dout <= w_sum;
      r_cout <= w_cnt1;
    end else if (w_ofire) begin
      r_vb <= 1'b0;
    end
  end

  assign valid_b  = r_vb;
  assign data_out = r_dout;
  assign cnt_out  = r_cout;

endmodule

// File: tb/tb_valid_ready_accum_n.sv
// Bench for valid_ready_accum_n: unsigned and signed
// instances share stimulus and an integer-level group model.
module tb_valid_ready_accum_n;

  localparam int DW    = 8;
  localparam int MAX_N = 16;
  localparam int NW    = $clog2(MAX_N+1);
  localparam int OW    = DW + $clog2(MAX_N);

  logic          clk;
  logic          rst_n;
  logic [NW-1:0] cfg_n;
  logic [DW-1:0] data_in;
  logic          valid_a;
  logic          last_a;
  logic          ready_b;
  logic          ready_a,  s_ready_a;
  logic          valid_b,  s_valid_b;
  logic [OW-1:0] data_out, s_data_out;
  logic [NW-1:0] cnt_out,  s_cnt_out;

  int checks = 0;
  int errors = 0;

  valid_ready_accum_n #(.DW(DW), .MAX_N(MAX_N), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .data_in(data_in),
    .valid_a(valid_a), .last_a(last_a), .ready_a(ready_a),
    .valid_b(valid_b), .ready_b(ready_b),
    .data_out(data_out), .cnt_out(cnt_out)
  );

  valid_ready_accum_n #(.DW(DW), .MAX_N(MAX_N), .SIGNED(1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .data_in(data_in),
    .valid_a(valid_a), .last_a(last_a), .ready_a(s_ready_a),
    .valid_b(s_valid_b), .ready_b(ready_b),
    .data_out(s_data_out), .cnt_out(s_cnt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int eff(int c);
    if (c == 0) return 1;
    if (c > MAX_N) return MAX_N;
    return c;
  endfunction

  // Model: a group is a running integer sum plus beat count
  bit     m_inprog, m_vb;
  int     m_cnt, m_len, m_co;
  longint m_su, m_ss, m_du, m_ds;

  longint q_u[$];
  longint q_s[$];
  int     q_c[$];

  // Compare before the edge, then advance the model across it
  always @(negedge clk) begin
    logic [OW-1:0] eu, es;
    bit cl, rdy, fire;
    if (!rst_n) begin
      m_inprog = 0; m_vb = 0; m_cnt = 0; m_len = 0; m_co = 0;
      m_su = 0; m_ss = 0; m_du = 0; m_ds = 0;
    end
    eu = OW'(m_du);
    es = OW'(m_ds);
    chk("valid_b", longint'(valid_b), longint'(m_vb));
    chk("s_valid_b", longint'(s_valid_b), longint'(m_vb));
    chk("data_out", longint'(data_out), longint'(eu));
    chk("s_data_out", longint'(s_data_out), longint'(es));
    chk("cnt_out", longint'(cnt_out), longint'(m_co));
    chk("s_cnt_out", longint'(s_cnt_out), longint'(m_co));
    if (rst_n) begin
      if (valid_b && ready_b) begin
        q_u.push_back(longint'(data_out));
        q_s.push_back(longint'(s_data_out));
        q_c.push_back(int'(cnt_out));
      end
      if (!m_inprog) m_len = eff(int'(cfg_n));
      cl  = last_a || (m_cnt + 1 == m_len);
      rdy = !m_vb || ready_b || !cl;
      chk("ready_a", longint'(ready_a), longint'(rdy));
      chk("s_ready_a", longint'(s_ready_a), longint'(rdy));
      fire = valid_a && rdy;
      if (m_vb && ready_b) m_vb = 0;
      if (fire) begin
        if (!m_inprog) begin
          m_su = 0; m_ss = 0; m_cnt = 0;
        end
        m_su += longint'(data_in);
        m_ss += longint'($signed(data_in));
        m_cnt++;
        if (cl) begin
          m_vb = 1; m_du = m_su; m_ds = m_ss; m_co = m_cnt;
          m_inprog = 0; m_cnt = 0;
        end else begin
          m_inprog = 1;
        end
      end
    end
  end

  task automatic beat(int d, bit l);
    bit f;
    int n;
    n = 0;
    valid_a = 1'b1;
    data_in = DW'(d);
    last_a  = l;
    forever begin
      @(negedge clk);
      f = ready_a;
      @(posedge clk);
      #2;
      if (f) break;
      n++;
      if (n > 50) begin
        errors++;
        $display("FAIL beat_timeout actual=stalled required=accepted");
        break;
      end
    end
    valid_a = 1'b0;
    last_a  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pop(string nm, longint eu, longint es, int ec);
    checks++;
    if (q_u.size() == 0) begin
      errors++;
      $display("FAIL %s actual=no_result required=%0d", nm, eu);
    end else begin
      chk({nm, "_u"}, q_u.pop_front(), eu);
      chk({nm, "_s"}, q_s.pop_front(), es);
      chk({nm, "_c"}, longint'(q_c.pop_front()), longint'(ec));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_n = '0;
    data_in = '0;
    valid_a = 1'b0;
    last_a = 1'b0;
    ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid_b", longint'(valid_b), 0);
    chk("rst_data_out", longint'(data_out), 0);
    chk("rst_cnt_out", longint'(cnt_out), 0);
    rst_n = 1'b1;
    idle(1);

    // Fixed length of 4
    cfg_n = NW'(4);
    for (int i = 1; i <= 8; i++) beat(i, 1'b0);
    idle(3);
    pop("fix1", 10, 10, 4);
    pop("fix2", 26, 26, 4);

    // Early terminate; cfg change mid-group is ignored
    cfg_n = NW'(8);
    beat(10, 1'b0);
    cfg_n = NW'(2);
    beat(20, 1'b0);
    beat(30, 1'b1);
    beat(1, 1'b0);
    beat(1, 1'b0);
    idle(3);
    pop("early", 60, 60, 3);
    pop("fresh", 2, 2, 2);

    // Backpressure
    cfg_n = NW'(2);
    beat(1, 1'b0);
    beat(2, 1'b0);
    ready_b = 1'b0;
    beat(4, 1'b0);
    valid_a = 1'b1;
    data_in = DW'(5);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_a", longint'(ready_a), 0);
      chk("bp_hold", longint'(data_out), 3);
    end
    @(posedge clk);
    #2;
    ready_b = 1'b1;
    @(negedge clk);
    chk("bp_release", longint'(ready_a), 1);
    @(posedge clk);
    #2;
    valid_a = 1'b0;
    @(negedge clk);
    chk("bp_vb", longint'(valid_b), 1);
    chk("bp_data", longint'(data_out), 9);
    chk("bp_cnt", longint'(cnt_out), 2);
    idle(2);
    pop("bp1", 3, 3, 2);
    pop("bp2", 9, 9, 2);

    // Length 0 acts as 1
    cfg_n = NW'(0);
    for (int i = 0; i < 3; i++) beat(7, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) pop("len0", 7, 7, 1);

    // Oversize length clamps to MAX_N, full-scale sum
    cfg_n = NW'(31);
    for (int i = 0; i < 16; i++) beat(255, 1'b0);
    idle(3);
    pop("max", 4080, 4080, 16);

    // Signed extension
    cfg_n = NW'(3);
    beat(8'h80, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'h01, 1'b0);
    idle(3);
    pop("signed", 384, 12'hF80, 3);

    // Reset mid-group discards pending and partial state
    ready_b = 1'b0;
    cfg_n = NW'(1);
    beat(9, 1'b0);
    cfg_n = NW'(4);
    beat(1, 1'b0);
    beat(2, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_b", longint'(valid_b), 0);
    chk("arst_data_out", longint'(data_out), 0);
    chk("arst_cnt_out", longint'(cnt_out), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_b = 1'b1;
    for (int i = 3; i <= 6; i++) beat(i, 1'b0);
    idle(3);
    pop("post_rst", 18, 18, 4);
    chk("q_empty", longint'(q_u.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
